reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes rst_n release, holds the DUT in reset for a fixed
// number of cycles, then runs; supports counted soft resets and a sticky run watchdog.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 4,
  parameter int SOFT_RST_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soft_rst_req,
  output logic        dut_rst_n,
  output logic        ready,
  output logic        start_pulse,
  output logic [31:0] run_cycles,
  output logic [7:0]  soft_rst_count,
  output logic        timeout
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;

  typedef enum logic [1:0] {SYNC, HOLD, RUN, SOFT} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [HW-1:0]          hold_cnt, hold_cnt_nx;
  logic [SW-1:0]          soft_cnt, soft_cnt_nx;
  logic                   armed, armed_nx;
  logic                   dut_rst_n_nx, ready_nx, start_nx, timeout_nx;
  logic [31:0]            run_nx;
  logic [7:0]             cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= SYNC;
      sync           <= '0;
      hold_cnt       <= '0;
      soft_cnt       <= '0;
      armed          <= 1'b1;
      dut_rst_n      <= 1'b0;
      ready          <= 1'b0;
      start_pulse    <= 1'b0;
      run_cycles     <= '0;
      soft_rst_count <= '0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_nx;
      sync           <= {sync[SYNC_STAGES-2:0], 1'b1};
      hold_cnt       <= hold_cnt_nx;
      soft_cnt       <= soft_cnt_nx;
      armed          <= armed_nx;
      dut_rst_n      <= dut_rst_n_nx;
      ready          <= ready_nx;
      start_pulse    <= start_nx;
      run_cycles     <= run_nx;
      soft_rst_count <= cnt_nx;
      timeout        <= timeout_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    soft_cnt_nx  = soft_cnt;
    // a request must drop low before another one is accepted
    armed_nx     = armed | ~soft_rst_req;
    dut_rst_n_nx = dut_rst_n;
    ready_nx     = ready;
    start_nx     = 1'b0;
    run_nx       = run_cycles;
    cnt_nx       = soft_rst_count;
    timeout_nx   = timeout;
    case (state)
      SYNC: begin
        if (sync[SYNC_STAGES-1]) begin
          state_nx    = HOLD;
          hold_cnt_nx = '0;
        end
      end
      HOLD: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_nx     = RUN;
          dut_rst_n_nx = 1'b1;
          ready_nx     = 1'b1;
          start_nx     = 1'b1;
          run_nx       = '0;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (soft_rst_req && armed) begin
          state_nx     = SOFT;
          soft_cnt_nx  = '0;
          armed_nx     = 1'b0;
          dut_rst_n_nx = 1'b0;
          ready_nx     = 1'b0;
          run_nx       = '0;
          cnt_nx       = (soft_rst_count == 8'hFF) ? soft_rst_count : soft_rst_count + 8'd1;
        end else begin
          run_nx = run_cycles + 32'd1;
          if (TIMEOUT_CYCLES != 0 && run_nx == 32'(TIMEOUT_CYCLES))
            timeout_nx = 1'b1;
        end
      end
      SOFT: begin
        if (soft_cnt == SW'(SOFT_RST_CYCLES - 1)) begin
          state_nx     = RUN;
          dut_rst_n_nx = 1'b1;
          ready_nx     = 1'b1;
          start_nx     = 1'b1;
          run_nx       = '0;
        end else begin
          soft_cnt_nx = soft_cnt + 1'b1;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, watchdog and short-latency builds
// share one clock, each with its own reset and soft request.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, rst2;
  logic        req0, req1, req2;
  logic        dut0, rdy0, st0, to0;
  logic        dut1, rdy1, st1, to1;
  logic        dut2, rdy2, st2, to2;
  logic [31:0] rc0, rc1, rc2;
  logic [7:0]  sc0, sc1, sc2;

  int checks = 0;
  int errors = 0;

  reset_sequencer u0 (
    .clk(clk), .rst_n(rst0), .soft_rst_req(req0), .dut_rst_n(dut0), .ready(rdy0),
    .start_pulse(st0), .run_cycles(rc0), .soft_rst_count(sc0), .timeout(to0));

  reset_sequencer #(.TIMEOUT_CYCLES(20)) u1 (
    .clk(clk), .rst_n(rst1), .soft_rst_req(req1), .dut_rst_n(dut1), .ready(rdy1),
    .start_pulse(st1), .run_cycles(rc1), .soft_rst_count(sc1), .timeout(to1));

  reset_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst2), .soft_rst_req(req2), .dut_rst_n(dut2), .ready(rdy2),
    .start_pulse(st2), .run_cycles(rc2), .soft_rst_count(sc2), .timeout(to2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    tick(3);

    // reset state
    chk("rst_dut", dut0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_start", st0, 0);
    chk("rst_run", rc0, 0);
    chk("rst_count", sc0, 0);
    chk("rst_timeout", to0, 0);

    // release latency 7, one-cycle start pulse
    rst0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rel_dut_low", dut0, 0);
    end
    tick();
    chk("rel_dut_high", dut0, 1);
    chk("rel_ready", rdy0, 1);
    chk("rel_start", st0, 1);
    chk("rel_run0", rc0, 0);
    tick();
    chk("rel_start_clr", st0, 0);
    chk("rel_run1", rc0, 1);
    tick(4);
    chk("rel_run5", rc0, 5);

    // single soft-reset pulse
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    chk("soft_dut0", dut0, 0);
    chk("soft_ready", rdy0, 0);
    chk("soft_run", rc0, 0);
    chk("soft_count", sc0, 1);
    tick();
    chk("soft_dut1", dut0, 0);
    tick();
    chk("soft_dut2", dut0, 0);
    tick();
    chk("soft_dut_back", dut0, 1);
    chk("soft_start", st0, 1);
    chk("soft_run0", rc0, 0);
    tick();
    chk("soft_start_clr", st0, 0);
    chk("soft_run1", rc0, 1);

    // held request counts once
    req0 = 1'b1;
    tick(10);
    req0 = 1'b0;
    tick(3);
    chk("held_count", sc0, 2);
    chk("held_ready", rdy0, 1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      tick(4);
    end
    chk("sat_count", sc0, 255);
    chk("sat_ready", rdy0, 1);

    // async reset from RUN takes effect mid-cycle
    #2 rst0 = 1'b0;
    #1;
    chk("async_count", sc0, 0);
    chk("async_ready", rdy0, 0);
    chk("async_dut", dut0, 0);
    chk("async_run", rc0, 0);
    tick();
    rst0 = 1'b1;
    tick(5);
    chk("hold_dut", dut0, 0);
    // 1 ns glitch while hold_cnt == 2
    rst0 = 1'b0;
    #1 rst0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rerel_dut_low", dut0, 0);
    end
    tick();
    chk("rerel_dut_high", dut0, 1);
    chk("rerel_start", st0, 1);

    // reset wins over a simultaneous soft request
    tick(2);
    req0 = 1'b1;
    rst0 = 1'b0;
    tick();
    chk("prec_count", sc0, 0);
    req0 = 1'b0;

    // watchdog build
    rst1 = 1'b1;
    tick(7);
    chk("wd_enter", rdy1, 1);
    tick(19);
    chk("wd_run19", rc1, 19);
    chk("wd_to_pre", to1, 0);
    tick();
    chk("wd_run20", rc1, 20);
    chk("wd_to_set", to1, 1);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk("wd_soft_run", rc1, 0);
    chk("wd_to_soft", to1, 1);
    tick(3);
    chk("wd_back", st1, 1);
    tick(25);
    chk("wd_to_hold", to1, 1);
    #2 rst1 = 1'b0;
    #1;
    chk("wd_to_clr", to1, 0);

    // short-latency build: 3 sync stages, 1 hold cycle
    rst2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("s3_dut_low", dut2, 0);
    end
    tick();
    chk("s3_dut_high", dut2, 1);
    chk("s3_start", st2, 1);
    chk("s3_ready", rdy2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
